// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
//   parity_e : line encoding of parity_mode
//   state_e  : transmitter frame state
//   eff_div  : maps the runtime divisor to clocks-per-bit
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_MARK = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // 0 selects the build-time default rate; 1 would leave no room for the
  // counter to reach D-1 after a restart, so it is clamped to 2.
  function automatic logic [31:0] eff_div(input logic [31:0] div,
                                          input logic [31:0] dflt);
    if (div == 32'd0)      return dflt;
    else if (div == 32'd1) return 32'd2;
    else                   return div;
  endfunction

  // Parity bit for a frame given the XOR reduction of its data bits.
  function automatic logic par_bit(input parity_e pm, input logic data_xor);
    case (pm)
      PAR_EVEN: return data_xor;
      PAR_ODD:  return ~data_xor;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side bus of the UART transmitter: character handshake plus the
// per-frame configuration that is latched at acceptance.
//   master : producer (drives data/valid/config, sees ready)
//   slave  : transmitter
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
);
  logic [DATA_BITS-1:0] data_in;
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic [1:0]           parity_mode;
  logic                 two_stop;
  logic [DIV_WIDTH-1:0] baud_div;

  modport master (
    output data_in, data_in_valid, parity_mode, two_stop, baud_div,
    input  data_in_ready
  );

  modport slave (
    input  data_in, data_in_valid, parity_mode, two_stop, baud_div,
    output data_in_ready
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer. Counts 0..D-1 while run is high and flags the last
// cycle of each bit. restart zeroes the counter and loads a new divisor.
//   clk, reset_n : clock, async active-low reset
//   restart      : load div_in, counter to 0 (frame accept)
//   run          : frame in progress
//   div_in       : effective clocks per bit (>= 2)
//   bit_end      : counter == D-1 while running
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 restart,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;

  assign bit_end = run && (cnt_q == div_q - DIV_WIDTH'(1));

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (restart) begin
      cnt_d = '0;
      div_d = div_in;
    end else if (run) begin
      // Return to 0 on the boundary itself, so there is no extra wrap cycle.
      cnt_d = bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (DATA_BITS 5..8, optional parity,
// one or two stop bits, per-frame baud divisor, zero-gap back-to-back).
//   clk, reset_n : clock, async active-low reset
//   bus          : character handshake + per-frame config (slave side)
//   serial_out   : registered UART line, idle high
//   tx_busy      : frame in progress
//   tx_done      : one-cycle pulse in the last cycle of the final stop bit
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_tx_cfg_if.slave  bus,
  output logic          serial_out,
  output logic          tx_busy,
  output logic          tx_done
);

  localparam int DEF_DIV = CLOCK_FREQ / BAUD_RATE;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 par_en_q, par_en_d;
  logic                 par_val_q, par_val_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 serial_out_q, serial_out_d;

  logic                 bit_end;
  logic                 last_stop;
  logic                 accept;
  logic                 load_frame;
  logic [DIV_WIDTH-1:0] div_eff;
  parity_e              pm;

  assign pm      = parity_e'(bus.parity_mode);
  assign div_eff = DIV_WIDTH'(eff_div(32'(bus.baud_div), 32'(DEF_DIV)));

  // Final cycle of the final stop bit: the frame ends here, and a new
  // character may be taken so its start bit follows with no idle gap.
  assign last_stop = (state_q == STOP) && (stop_idx_q || !two_stop_q) && bit_end;

  assign bus.data_in_ready = (state_q == IDLE) || last_stop;
  assign accept            = bus.data_in_valid && bus.data_in_ready;

  assign serial_out = serial_out_q;
  assign tx_busy    = (state_q != IDLE);
  assign tx_done    = last_stop;

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (accept),
    .run     (tx_busy),
    .div_in  (div_eff),
    .bit_end (bit_end)
  );

  // serial_out_d always reflects the bit of the state being entered, so the
  // registered line changes on the same edge as the state.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    par_en_d     = par_en_q;
    par_val_d    = par_val_q;
    two_stop_d   = two_stop_q;
    stop_idx_d   = stop_idx_q;
    serial_out_d = serial_out_q;
    load_frame   = 1'b0;

    unique case (state_q)
      IDLE: begin
        serial_out_d = 1'b1;
        load_frame   = accept;
      end
      START: begin
        if (bit_end) begin
          state_d      = DATA;
          bit_idx_d    = '0;
          serial_out_d = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d      = PARITY;
              serial_out_d = par_val_q;
            end else begin
              state_d      = STOP;
              stop_idx_d   = 1'b0;
              serial_out_d = 1'b1;
            end
          end else begin
            bit_idx_d    = bit_idx_q + 3'd1;
            shreg_d      = shreg_q >> 1;
            serial_out_d = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d      = STOP;
          stop_idx_d   = 1'b0;
          serial_out_d = 1'b1;
        end
      end
      STOP: begin
        if (last_stop) begin
          if (accept) begin
            load_frame = 1'b1;
          end else begin
            state_d      = IDLE;
            serial_out_d = 1'b1;
          end
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        serial_out_d = 1'b1;
      end
    endcase

    // Everything the frame needs is captured here; later input changes
    // cannot reach the line until the next accept.
    if (load_frame) begin
      state_d      = START;
      serial_out_d = 1'b0;
      shreg_d      = bus.data_in;
      par_en_d     = (pm != PAR_NONE);
      par_val_d    = par_bit(pm, ^bus.data_in);
      two_stop_d   = bus.two_stop;
      stop_idx_d   = 1'b0;
      bit_idx_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      par_en_q     <= 1'b0;
      par_val_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      stop_idx_q   <= 1'b0;
      serial_out_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      par_en_q     <= par_en_d;
      par_val_q    <= par_val_d;
      two_stop_q   <= two_stop_d;
      stop_idx_q   <= stop_idx_d;
      serial_out_q <= serial_out_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: an 8-bit and a 7-bit instance. Each accepted frame
// pushes its expected per-cycle {serial_out, tx_busy, tx_done, ready} into a
// queue; a negedge monitor pops and compares one entry per cycle.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8), .DIV_WIDTH(16)) if8 ();
  uart_tx_cfg_if #(.DATA_BITS(7), .DIV_WIDTH(16)) if7 ();

  logic s8, b8, d8, s7, b7, d7;

  uart_tx_cfg #(.CLOCK_FREQ(125_000_000), .BAUD_RATE(115_200), .DATA_BITS(8), .DIV_WIDTH(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(if8), .serial_out(s8), .tx_busy(b8), .tx_done(d8));

  uart_tx_cfg #(.CLOCK_FREQ(125_000_000), .BAUD_RATE(115_200), .DATA_BITS(7), .DIV_WIDTH(16)) dut7 (
    .clk(clk), .reset_n(reset_n), .bus(if7), .serial_out(s7), .tx_busy(b7), .tx_done(d7));

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] q8[$];
  logic [3:0] q7[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame model: entry = {line, busy, done, ready}.
  function automatic void push_frame(input bit w7, input logic [7:0] d, input int nb,
                                     input logic [1:0] pm, input logic ts, input int bd,
                                     input bit tail);
    int   dv;
    logic x;
    logic bits[$];
    logic [3:0] e;
    bit   last;
    dv = (bd == 0) ? 1085 : (bd == 1) ? 2 : bd;
    x = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      x = x ^ d[i];
    end
    case (pm)
      2'b01: bits.push_back(x);
      2'b10: bits.push_back(~x);
      2'b11: bits.push_back(1'b1);
      default: ;
    endcase
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < dv; c++) begin
        last = (b == bits.size() - 1) && (c == dv - 1);
        e = {bits[b], 1'b1, last, last};
        if (w7) q7.push_back(e); else q8.push_back(e);
      end
    if (tail)
      for (int i = 0; i < 2; i++)
        if (w7) q7.push_back(4'b1001); else q8.push_back(4'b1001);
  endfunction

  always @(negedge clk) begin
    if (q8.size() > 0) chk("dut8_cycle", {28'd0, s8, b8, d8, if8.data_in_ready}, {28'd0, q8.pop_front()});
    if (q7.size() > 0) chk("dut7_cycle", {28'd0, s7, b7, d7, if7.data_in_ready}, {28'd0, q7.pop_front()});
  end

  task automatic drain();
    int n = 0;
    while ((q8.size() > 0 || q7.size() > 0) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Returns at accept edge + 1.
  task automatic wait_accept(input bit w7);
    bit got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if ((w7 ? if7.data_in_ready : if8.data_in_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                       input logic [15:0] bd, input bit keep, input bit tail);
    @(posedge clk);
    #1;
    if8.data_in = d; if8.parity_mode = pm; if8.two_stop = ts; if8.baud_div = bd;
    if8.data_in_valid = 1'b1;
    wait_accept(1'b0);
    push_frame(1'b0, d, 8, pm, ts, int'(bd), tail);
    if (!keep) if8.data_in_valid = 1'b0;
  endtask

  initial begin
    if8.data_in = 8'h55; if8.data_in_valid = 1'b1; if8.parity_mode = 2'b00;
    if8.two_stop = 1'b0; if8.baud_div = 16'd4;
    if7.data_in = 7'h00; if7.data_in_valid = 1'b0; if7.parity_mode = 2'b00;
    if7.two_stop = 1'b0; if7.baud_div = 16'd3;

    // Reset held with valid high: nothing may start.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", {31'd0, s8}, 32'd1);
    chk("rst_ready", {31'd0, if8.data_in_ready}, 32'd1);
    chk("rst_busy", {31'd0, b8}, 32'd0);
    chk("rst_done", {31'd0, d8}, 32'd0);
    if8.data_in_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_line", {31'd0, s8}, 32'd1);
      chk("idle_busy", {31'd0, b8}, 32'd0);
      chk("idle_ready", {31'd0, if8.data_in_ready}, 32'd1);
    end

    // Even parity, D=4: 44-cycle frame.
    send8(8'hA5, 2'b01, 1'b0, 16'd4, 1'b0, 1'b1);
    drain();

    // Odd parity with inputs changed mid-frame; the frame must not notice.
    send8(8'hA5, 2'b10, 1'b0, 16'd4, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    if8.baud_div = 16'd9; if8.parity_mode = 2'b00; if8.two_stop = 1'b1; if8.data_in = 8'h00;
    drain();

    // Divisor 1 clamps to 2; mark parity.
    send8(8'h3C, 2'b11, 1'b0, 16'd1, 1'b0, 1'b1);
    drain();

    // Seven data bits, two stop bits, D=3: 30-cycle frame.
    @(posedge clk);
    #1;
    if7.data_in = 7'h41; if7.parity_mode = 2'b00; if7.two_stop = 1'b1; if7.baud_div = 16'd3;
    if7.data_in_valid = 1'b1;
    wait_accept(1'b1);
    push_frame(1'b1, 8'h41, 7, 2'b00, 1'b1, 3, 1'b1);
    if7.data_in_valid = 1'b0;
    drain();

    // Back-to-back with valid held: zero gap, busy continuous.
    send8(8'h00, 2'b00, 1'b0, 16'd2, 1'b1, 1'b0);
    @(posedge clk);
    #1 if8.data_in = 8'hFF;
    wait_accept(1'b0);
    push_frame(1'b0, 8'hFF, 8, 2'b00, 1'b0, 2, 1'b1);
    if8.data_in_valid = 1'b0;
    drain();

    // Async reset during DATA of an all-zero character.
    send8(8'h00, 2'b00, 1'b0, 16'd4, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_line", {31'd0, s8}, 32'd0);
    #1;
    reset_n = 1'b0;
    q8.delete();
    #1;
    chk("async_rst_line", {31'd0, s8}, 32'd1);
    chk("async_rst_busy", {31'd0, b8}, 32'd0);
    chk("async_rst_done", {31'd0, d8}, 32'd0);
    chk("async_rst_ready", {31'd0, if8.data_in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Default divisor after reset: 1085 cycles per bit.
    send8(8'h3C, 2'b00, 1'b0, 16'd0, 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
